apb_uart_tx: RTL and testbench
==============================

Name: apb_uart_tx

Overview:
- APB slave (responder) UART transmitter: the far end of the APB master driven by the UART bench interface.
- Accepts bytes over APB into a TX FIFO and serializes them on TXD as 8N1 frames, LSB first.
- Exposes a programmable baud divisor, a status register and a level IRQ.
- Sits between the APB fabric and the UART pin; paired with the existing UART RX path.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, range 2..256.
- DIV_RST, 16'd27, reset value of the DIV register.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- Preset  in  1  asynchronous, active-high reset.
- Paddr  in  32  APB address; only bits [3:2] decoded, [31:4] must be 0.
- Psel  in  1  APB select.
- Penable  in  1  APB access phase.
- Pwrite  in  1  1 = write, 0 = read.
- Pwdata  in  32  APB write data.
- Prdata  out  32  APB read data.
- Pready  out  1  transfer ready.
- Pslverr  out  1  transfer error.
- IRQ  out  1  level interrupt.
- TXD  out  1  serial output; idle high.
- baud_o  out  1  one-clk 16x oversample tick.

Behaviour:
- Reset (async, Preset=1): TXD=1, IRQ=0, baud_o=0, Prdata=0, Pslverr=0, Pready=1. FIFO empties, FSM goes to IDLE, DIV=DIV_RST, IER=0, baud counter=0.
- APB:
  - Zero wait states; Pready=1 always.
  - A transfer completes in the cycle with Psel&Penable.
  - Prdata and Pslverr are combinational in that cycle and 0 otherwise.
- Register map:
  - 0x0 THR (WO): write pushes Pwdata[7:0].
  - 0x4 DIV (RW): bits [15:0]; upper bits read 0.
  - 0x8 STATUS (RO): bit0 fifo_empty, bit1 fifo_full, bit2 tx_busy, bits [15:8] fifo_count.
  - 0xC IER (RW): bit0 tx_empty_ie.
- Pslverr=1, no state change, when any of:
  - Paddr[31:4] != 0;
  - write to STATUS;
  - read of THR (Prdata=0);
  - write to THR while fifo_full. The byte is dropped even if a pop occurs the same cycle.
- Baud generator:
  - 16-bit counter increments every clk.
  - When counter==DIV: baud_o=1 for one clk and the counter reloads 0. Tick period is DIV+1 clks.
  - DIV=0 gives baud_o=1 every clk.
  - A DIV write resets the counter to 0 in the same cycle.
- Bit time = 16 baud ticks.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when enabled).
  - IDLE: TXD=1. On a tick with FIFO non-empty: pop head into shift register, go to START, tx_busy=1.
  - START: TXD=0 for 16 ticks.
  - DATA: TXD=shift[0]; shift right after each 16 ticks; 3-bit index counts 8 bits.
  - STOP: TXD=1 for 16 ticks. Then pop the next byte directly into START if FIFO non-empty (back-to-back frames, no idle gap); otherwise go to IDLE and set tx_busy=0.
  - Frame start jitter from IDLE is at most one tick.
- FIFO:
  - Circular with log2(FIFO_DEPTH)+1 pointers; wrap-around is transparent.
  - Push and pop in the same cycle when not full: count unchanged.
- IRQ: registered; IRQ = IER[0] & fifo_empty & ~tx_busy, updated one clk after the condition changes.
- TXD is registered (glitch-free).
- Reset mid-frame aborts immediately: TXD=1, and the partial frame is lost.

Optional Feature:
- Macro: APB_UART_TX_PARITY_EN.
- Defined:
  - Adds LCR register at 0xC bits [2:1]: bit1 parity_en, bit2 odd. Resets 0. IER stays bit0 of the same register.
  - When parity_en=1, a PARITY state (16 ticks) between DATA and STOP drives XOR of the 8 data bits, inverted when odd=1.
- Undefined: no PARITY state; bits [2:1] at 0xC read 0 and ignore writes; frames are strictly 8N1.

Test Plan:
- Reset, then read 0x4/0x8/0xC -> 0x1B / 0x00000001 / 0x0; TXD=1; Pslverr=0.
- DIV=0, write THR=0xA5 -> TXD sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 clks; STATUS.tx_busy=0 and fifo_empty=1 after the stop bit.
- DIV=3: check baud_o period 4 clks. Write DIV=7 mid-count -> next baud_o 8 clks after the write.
- IER=1, FIFO_DEPTH=8: write 9 bytes back-to-back with the TX stalled. 9th write gets Pslverr=1; STATUS bit1=1, count=8. All 8 frames then emit with no idle gap; IRQ rises 1 clk after the final stop bit.
- Read THR, write STATUS, access Paddr=0x10 -> Pslverr=1 each; register contents unchanged.
- Assert Preset during bit 3 of a frame -> TXD=1 in the same cycle (async); FIFO count=0 after release. With APB_UART_TX_PARITY_EN and LCR=0x2, byte 0x07 -> parity bit 1.

Source files
------------

// File: rtl/apb_uart_tx_if.sv
// APB bus bundle between the fabric master and the UART TX responder.
// Zero-wait-state protocol: a transfer completes when Psel & Penable.
interface apb_uart_tx_if;
  logic [31:0] Paddr;
  logic        Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  modport master (
    output Paddr, Psel, Penable, Pwrite, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Paddr, Psel, Penable, Pwrite, Pwdata,
    output Prdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_uart_tx.sv
// APB UART transmitter: TX FIFO, baud tick generator and 8N1 serializer.
// Define APB_UART_TX_PARITY_EN to add the LCR parity bits and PARITY state.
module apb_uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RST    = 16'd27
) (
  input  logic           clk,
  input  logic           Preset,
  apb_uart_tx_if.slave   apb,
  output logic           IRQ,
  output logic           TXD,
  output logic           baud_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] A_THR = 2'd0;
  localparam logic [1:0] A_DIV = 2'd1;
  localparam logic [1:0] A_ST  = 2'd2;
  localparam logic [1:0] A_IER = 2'd3;

  typedef logic [AW:0] ptr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef APB_UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  // APB decode
  logic        acc;
  logic        addr_ok;
  logic [1:0]  sel;
  logic        err;
  logic        ok;
  logic        thr_wr;
  logic        div_wr;
  logic        ier_wr;
  logic [31:0] rdata;

  // registers
  logic [15:0] div_q, div_d;
  logic        ier_q, ier_d;
`ifdef APB_UART_TX_PARITY_EN
  logic [1:0]  lcr_q, lcr_d;
`endif

  // baud generator
  logic [15:0] cnt_q, cnt_d;
  logic        baud_q, baud_d;
  logic        tick;

  // fifo
  logic [7:0]  mem_q [FIFO_DEPTH];
  ptr_t        wr_q, wr_d;
  ptr_t        rd_q, rd_d;
  ptr_t        count;
  logic [8:0]  cnt9;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [7:0]  head;

  // serializer
  state_t      state_q;
  logic [3:0]  tcnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  sh_q;
  logic        busy_q;
  logic        txd_q;
  logic        last;
`ifdef APB_UART_TX_PARITY_EN
  logic        par_q;
`endif

  logic        irq_q, irq_d;
  logic        unused_ok;

  assign acc     = apb.Psel & apb.Penable;
  assign addr_ok = (apb.Paddr[31:4] == 28'd0);
  assign sel     = apb.Paddr[3:2];

  always_comb begin
    err = 1'b0;
    if (acc) begin
      if (!addr_ok)
        err = 1'b1;
      else if (apb.Pwrite && sel == A_ST)
        err = 1'b1;
      else if (!apb.Pwrite && sel == A_THR)
        err = 1'b1;
      else if (apb.Pwrite && sel == A_THR && full)
        err = 1'b1;
    end
  end

  assign ok     = acc & ~err;
  assign thr_wr = ok & apb.Pwrite & (sel == A_THR);
  assign div_wr = ok & apb.Pwrite & (sel == A_DIV);
  assign ier_wr = ok & apb.Pwrite & (sel == A_IER);

  assign cnt9 = 9'(count);

  always_comb begin
    rdata = 32'd0;
    if (ok && !apb.Pwrite) begin
      case (sel)
        A_DIV: rdata = {16'd0, div_q};
        A_ST:  rdata = {16'd0, cnt9[7:0], 5'd0,
                        busy_q, full, empty};
`ifdef APB_UART_TX_PARITY_EN
        A_IER: rdata = {29'd0, lcr_q, ier_q};
`else
        A_IER: rdata = {31'd0, ier_q};
`endif
        default: rdata = 32'd0;
      endcase
    end
  end

  assign apb.Prdata  = rdata;
  assign apb.Pready  = 1'b1;
  assign apb.Pslverr = err;

  always_comb begin
    div_d = div_q;
    ier_d = ier_q;
    if (div_wr)
      div_d = apb.Pwdata[15:0];
    if (ier_wr)
      ier_d = apb.Pwdata[0];
  end

`ifdef APB_UART_TX_PARITY_EN
  always_comb begin
    lcr_d = lcr_q;
    if (ier_wr)
      lcr_d = apb.Pwdata[2:1];
  end
`endif

  // a DIV write restarts the tick period from zero
  assign tick = ~div_wr & (cnt_q == div_q);

  always_comb begin
    cnt_d  = cnt_q + 16'd1;
    baud_d = tick;
    if (div_wr || tick)
      cnt_d = 16'd0;
  end

  assign count = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (count == ptr_t'(FIFO_DEPTH));
  assign head  = mem_q[rd_q[AW-1:0]];
  assign push  = thr_wr;

  assign last = tick & (tcnt_q == 4'd15);
  assign pop  = tick & ~empty &
                ((state_q == S_IDLE) ||
                 (state_q == S_STOP && tcnt_q == 4'd15));

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push)
      wr_d = wr_q + ptr_t'(1);
    if (pop)
      rd_d = rd_q + ptr_t'(1);
  end

  assign irq_d = ier_q & empty & ~busy_q;

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q[AW-1:0]] <= apb.Pwdata[7:0];
  end

  always_ff @(posedge clk or posedge Preset) begin
    if (Preset) begin
      div_q  <= DIV_RST;
      ier_q  <= 1'b0;
      cnt_q  <= 16'd0;
      baud_q <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      ier_q  <= ier_d;
      cnt_q  <= cnt_d;
      baud_q <= baud_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      irq_q  <= irq_d;
    end
  end

`ifdef APB_UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge Preset) begin
    if (Preset)
      lcr_q <= 2'd0;
    else
      lcr_q <= lcr_d;
  end
`endif

  always_ff @(posedge clk or posedge Preset) begin
    if (Preset) begin
      state_q <= S_IDLE;
      tcnt_q  <= 4'd0;
      idx_q   <= 3'd0;
      sh_q    <= 8'd0;
      busy_q  <= 1'b0;
      txd_q   <= 1'b1;
`ifdef APB_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (pop) begin
      // load from IDLE or straight out of STOP for back-to-back frames
      state_q <= S_START;
      tcnt_q  <= 4'd0;
      sh_q    <= head;
      busy_q  <= 1'b1;
      txd_q   <= 1'b0;
`ifdef APB_UART_TX_PARITY_EN
      par_q   <= (^head) ^ lcr_q[1];
`endif
    end else begin
      if (tick)
        tcnt_q <= tcnt_q + 4'd1;
      case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
        end
        S_START: begin
          if (last) begin
            state_q <= S_DATA;
            idx_q   <= 3'd0;
            txd_q   <= sh_q[0];
          end
        end
        S_DATA: begin
          if (last) begin
            sh_q  <= sh_q >> 1;
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef APB_UART_TX_PARITY_EN
              if (lcr_q[0]) begin
                state_q <= S_PARITY;
                txd_q   <= par_q;
              end else begin
                state_q <= S_STOP;
                txd_q   <= 1'b1;
              end
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              txd_q <= sh_q[1];
            end
          end
        end
`ifdef APB_UART_TX_PARITY_EN
        S_PARITY: begin
          if (last) begin
            state_q <= S_STOP;
            txd_q   <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (last) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            txd_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign TXD    = txd_q;
  assign IRQ    = irq_q;
  assign baud_o = baud_q;

  assign unused_ok = ^{apb.Paddr[1:0], apb.Pwdata[31:16],
                       cnt9[8], apb.Pready, apb.Prdata[0]};

endmodule

// File: tb/tb_apb_uart_tx.sv
// Directed self-checking bench for apb_uart_tx (FIFO_DEPTH=8, DIV_RST=27).
// Optional parity frame check runs when APB_UART_TX_PARITY_EN is defined.
module tb_apb_uart_tx;

  logic clk;
  logic Preset;
  logic IRQ;
  logic TXD;
  logic baud_o;

  int checks;
  int errors;

  logic [31:0] rd;
  logic        er;

  logic [7:0] bytes [9] = '{8'h00, 8'hFF, 8'h55, 8'hAA,
                            8'h0F, 8'hF0, 8'h81, 8'h3C, 8'hEE};

  apb_uart_tx_if bus ();

  apb_uart_tx #(
    .FIFO_DEPTH(8),
    .DIV_RST(16'd27)
  ) dut (
    .clk(clk),
    .Preset(Preset),
    .apb(bus.slave),
    .IRQ(IRQ),
    .TXD(TXD),
    .baud_o(baud_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] r,
                     output logic e);
    bus.Psel    = 1'b1;
    bus.Penable = 1'b0;
    bus.Pwrite  = wr;
    bus.Paddr   = a;
    bus.Pwdata  = d;
    @(posedge clk);
    #1;
    bus.Penable = 1'b1;
    #1;
    r = bus.Prdata;
    e = bus.Pslverr;
    @(posedge clk);
    #1;
    bus.Psel    = 1'b0;
    bus.Penable = 1'b0;
    bus.Pwrite  = 1'b0;
  endtask

  initial begin
    logic [9:0]  fr;
    logic [10:0] fp;
    checks = 0;
    errors = 0;
    Preset = 1'b1;
    bus.Psel    = 1'b0;
    bus.Penable = 1'b0;
    bus.Pwrite  = 1'b0;
    bus.Paddr   = 32'd0;
    bus.Pwdata  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", {31'd0, TXD}, 32'd1);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    chk("rst_baud", {31'd0, baud_o}, 32'd0);
    chk("rst_pready", {31'd0, bus.Pready}, 32'd1);
    chk("rst_prdata", bus.Prdata, 32'd0);
    Preset = 1'b0;

    apb(1'b0, 32'h4, 32'd0, rd, er);
    chk("rst_div", rd, 32'h1B);
    chk("rst_div_err", {31'd0, er}, 32'd0);
    apb(1'b0, 32'h8, 32'd0, rd, er);
    chk("rst_status", rd, 32'h1);
    apb(1'b0, 32'hC, 32'd0, rd, er);
    chk("rst_ier", rd, 32'h0);
    chk("rst_ier_err", {31'd0, er}, 32'd0);

    // single 0xA5 frame at one tick per clk
    apb(1'b1, 32'h4, 32'd0, rd, er);
    apb(1'b1, 32'h0, 32'hA5, rd, er);
    chk("thr_err", {31'd0, er}, 32'd0);
    chk("pre_frame_txd", {31'd0, TXD}, 32'd1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 160; i++) begin
      @(posedge clk);
      #1;
      chk("frame_a5", {31'd0, TXD}, {31'd0, fr[i/16]});
    end
    apb(1'b0, 32'h8, 32'd0, rd, er);
    chk("post_a5_status", rd, 32'h1);
    chk("post_a5_txd", {31'd0, TXD}, 32'd1);

    // baud tick period and DIV write restart
    apb(1'b1, 32'h4, 32'd3, rd, er);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      chk("baud_div3", {31'd0, baud_o}, {31'd0, (i % 4) == 0});
    end
    apb(1'b1, 32'h4, 32'd7, rd, er);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      chk("baud_div7", {31'd0, baud_o}, {31'd0, i == 8});
    end

    // fill FIFO with TX stalled, then drain back-to-back
    apb(1'b1, 32'h4, 32'hFFFF, rd, er);
    apb(1'b1, 32'hC, 32'h1, rd, er);
    @(posedge clk);
    #1;
    chk("irq_idle", {31'd0, IRQ}, 32'd1);
    for (int k = 0; k < 9; k++) begin
      apb(1'b1, 32'h0, {24'd0, bytes[k]}, rd, er);
      chk("fill_err", {31'd0, er}, {31'd0, k == 8});
    end
    apb(1'b0, 32'h8, 32'd0, rd, er);
    chk("full_status", rd, 32'h0802);
    chk("full_irq", {31'd0, IRQ}, 32'd0);
    apb(1'b1, 32'h4, 32'd0, rd, er);
    chk("drain_pre_txd", {31'd0, TXD}, 32'd1);
    for (int i = 0; i < 1280; i++) begin
      @(posedge clk);
      #1;
      fr = {1'b1, bytes[i/160], 1'b0};
      chk("drain_txd", {31'd0, TXD}, {31'd0, fr[(i%160)/16]});
    end
    @(posedge clk);
    #1;
    chk("drain_irq_lo", {31'd0, IRQ}, 32'd0);
    chk("drain_idle_txd", {31'd0, TXD}, 32'd1);
    @(posedge clk);
    #1;
    chk("drain_irq_hi", {31'd0, IRQ}, 32'd1);
    apb(1'b0, 32'h8, 32'd0, rd, er);
    chk("drain_status", rd, 32'h1);

    // error responses leave state untouched
    apb(1'b0, 32'h0, 32'd0, rd, er);
    chk("rd_thr_err", {31'd0, er}, 32'd1);
    chk("rd_thr_data", rd, 32'd0);
    apb(1'b1, 32'h8, 32'hFFFF, rd, er);
    chk("wr_st_err", {31'd0, er}, 32'd1);
    apb(1'b0, 32'h10, 32'd0, rd, er);
    chk("rd_hi_err", {31'd0, er}, 32'd1);
    chk("rd_hi_data", rd, 32'd0);
    apb(1'b1, 32'h14, 32'h55, rd, er);
    chk("wr_hi_div_err", {31'd0, er}, 32'd1);
    apb(1'b1, 32'h10, 32'h44, rd, er);
    chk("wr_hi_thr_err", {31'd0, er}, 32'd1);
    apb(1'b0, 32'h4, 32'd0, rd, er);
    chk("err_div_kept", rd, 32'd0);
    apb(1'b0, 32'hC, 32'd0, rd, er);
    chk("err_ier_kept", rd, 32'd1);
    apb(1'b0, 32'h8, 32'd0, rd, er);
    chk("err_status_kept", rd, 32'h1);

    // async reset during data bit 2 (frame bit 3)
    apb(1'b1, 32'h0, 32'h00, rd, er);
    repeat (57) @(posedge clk);
    #1;
    chk("mid_frame_txd", {31'd0, TXD}, 32'd0);
    #2;
    Preset = 1'b1;
    #1;
    chk("async_rst_txd", {31'd0, TXD}, 32'd1);
    chk("async_rst_irq", {31'd0, IRQ}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    Preset = 1'b0;
    apb(1'b0, 32'h8, 32'd0, rd, er);
    chk("post_rst_status", rd, 32'h1);
    apb(1'b0, 32'h4, 32'd0, rd, er);
    chk("post_rst_div", rd, 32'h1B);
    apb(1'b0, 32'hC, 32'd0, rd, er);
    chk("post_rst_ier", rd, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_txd", {31'd0, TXD}, 32'd1);

`ifdef APB_UART_TX_PARITY_EN
    apb(1'b1, 32'h4, 32'd0, rd, er);
    apb(1'b1, 32'hC, 32'h2, rd, er);
    apb(1'b0, 32'hC, 32'd0, rd, er);
    chk("lcr_rd", rd, 32'h2);
    apb(1'b1, 32'h0, 32'h07, rd, er);
    fp = {1'b1, 1'b1, 8'h07, 1'b0};
    for (int i = 0; i < 176; i++) begin
      @(posedge clk);
      #1;
      chk("parity_frame", {31'd0, TXD}, {31'd0, fp[i/16]});
    end
`else
    fp = '0;
    apb(1'b1, 32'hC, 32'h6, rd, er);
    apb(1'b0, 32'hC, 32'd0, rd, er);
    chk("lcr_absent", rd, 32'h0);
    apb(1'b1, 32'hC, 32'h7, rd, er);
    apb(1'b0, 32'hC, 32'd0, rd, er);
    chk("ier_only", rd, 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
